// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment driver: hex or sequential double-dabble decimal display with
// per-digit decimal points, leading-zero blanking, overflow dashes and a busy/load handshake.
module seg7_scan_ctrl #(
   parameter int DIGITS   = 8,
   parameter int PRESCALE = 100000
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  mode,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            segment
);

   localparam int VAL_W = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CNT_W = $clog2(VAL_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } conv_state_t;

   conv_state_t state, state_nxt;

   logic accept_hex, accept_dec, do_shift, do_commit;

   // conversion datapath
   logic [VAL_W-1:0]  bin, bcd, bcd_adj, bcd_shl, bin_shl;
   logic              shift_out;
   logic [CNT_W-1:0]  bit_cnt;
   logic              ovf_acc;
   logic [DIGITS-1:0] dp_pend;

   // committed display state
   logic [VAL_W-1:0]  disp_reg;
   logic [DIGITS-1:0] dp_reg;
   logic              disp_ovf;

   // scan state
   logic [PS_W-1:0]   ps;
   logic [IDX_W-1:0]  idx;
   logic [DIGITS-1:0] zero_from;
   logic [3:0]        nib;
   logic              dp_cur, lz_cur;
   logic [7:0]        seg_nxt;
   logic [DIGITS-1:0] an_nxt;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0:    hex_glyph = 7'h40;
         4'h1:    hex_glyph = 7'h79;
         4'h2:    hex_glyph = 7'h24;
         4'h3:    hex_glyph = 7'h30;
         4'h4:    hex_glyph = 7'h19;
         4'h5:    hex_glyph = 7'h12;
         4'h6:    hex_glyph = 7'h02;
         4'h7:    hex_glyph = 7'h78;
         4'h8:    hex_glyph = 7'h00;
         4'h9:    hex_glyph = 7'h10;
         4'hA:    hex_glyph = 7'h08;
         4'hB:    hex_glyph = 7'h03;
         4'hC:    hex_glyph = 7'h46;
         4'hD:    hex_glyph = 7'h21;
         4'hE:    hex_glyph = 7'h06;
         default: hex_glyph = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      accept_hex = 1'b0;
      accept_dec = 1'b0;
      do_shift   = 1'b0;
      do_commit  = 1'b0;
      case (state)
         S_IDLE: begin
            if (load) begin
               if (mode) begin
                  accept_dec = 1'b1;
                  state_nxt  = S_SHIFT;
               end else begin
                  accept_hex = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            do_shift = 1'b1;
            if (bit_cnt == CNT_W'(VAL_W - 1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            do_commit = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   // add-3 correction on every BCD nibble, then one combined left shift of {bcd,bin}
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign {shift_out, bcd_shl, bin_shl} = {bcd_adj, bin, 1'b0};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bin      <= '0;
         bcd      <= '0;
         bit_cnt  <= '0;
         ovf_acc  <= 1'b0;
         dp_pend  <= '0;
         disp_reg <= '0;
         dp_reg   <= '0;
         disp_ovf <= 1'b0;
      end else begin
         if (accept_hex) begin
            disp_reg <= value;
            dp_reg   <= dp;
            disp_ovf <= 1'b0;
         end
         if (accept_dec) begin
            bin     <= value;
            bcd     <= '0;
            bit_cnt <= '0;
            ovf_acc <= 1'b0;
            dp_pend <= dp;
         end
         if (do_shift) begin
            bin     <= bin_shl;
            bcd     <= bcd_shl;
            bit_cnt <= bit_cnt + 1'b1;
            ovf_acc <= ovf_acc | shift_out;
         end
         // digits, dp and overflow flag swap in together so the scan never shows a mix
         if (do_commit) begin
            disp_reg <= bcd;
            dp_reg   <= dp_pend;
            disp_ovf <= ovf_acc;
         end
      end
   end

   // zero_from[i] is set when nibbles i..DIGITS-1 are all zero
   always_comb begin : lz_scan
      logic acc;
      acc       = 1'b1;
      zero_from = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc          = acc & (disp_reg[4*i +: 4] == 4'd0);
         zero_from[i] = acc;
      end
   end

   always_comb begin
      nib    = '0;
      dp_cur = 1'b0;
      lz_cur = 1'b0;
      an_nxt = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nib       = disp_reg[4*i +: 4];
            dp_cur    = dp_reg[i];
            lz_cur    = zero_from[i];
            an_nxt[i] = 1'b0;
         end
      end
      if (disp_ovf)
         seg_nxt = {~dp_cur, 7'h3F};
      else if (blank_lz && (idx != '0) && lz_cur)
         seg_nxt = {~dp_cur, 7'h7F};
      else
         seg_nxt = {~dp_cur, hex_glyph(nib)};
   end

   // an/segment load on the same edge that advances idx, so they always change together
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ps      <= '0;
         idx     <= '0;
         an      <= '1;
         segment <= 8'hFF;
      end else if (ps == PS_W'(PRESCALE - 1)) begin
         ps      <= '0;
         idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
         an      <= an_nxt;
         segment <= seg_nxt;
      end else begin
         ps <= ps + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with DIGITS=4, PRESCALE=4.
module tb_seg7_scan_ctrl;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;

   logic        clk, clr, load, mode, blank_lz, busy;
   logic [15:0] value;
   logic [3:0]  dp, an;
   logic [7:0]  segment;

   int checks = 0;
   int errors = 0;
   int n;

   seg7_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
      .clk      (clk),
      .clr      (clr),
      .load     (load),
      .value    (value),
      .mode     (mode),
      .dp       (dp),
      .blank_lz (blank_lz),
      .busy     (busy),
      .an       (an),
      .segment  (segment)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ends on the negedge just after the accepting edge
   task automatic load_val(input logic [15:0] v, input logic m, input logic [3:0] d);
      @(negedge clk);
      value = v;
      mode  = m;
      dp    = d;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic expect_digit(input string tag, input int i, input logic [7:0] exp);
      logic [3:0] pat;
      int k;
      pat = ~(4'b0001 << i);
      k = 0;
      while (an !== pat && k < 64) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("%s_an%0d", tag, i), an, pat);
      check($sformatf("%s_seg%0d", tag, i), segment, exp);
   endtask

   task automatic expect_all(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
      repeat (16) @(negedge clk);
      expect_digit(tag, 0, e0);
      expect_digit(tag, 1, e1);
      expect_digit(tag, 2, e2);
      expect_digit(tag, 3, e3);
   endtask

   initial begin
      clr      = 1'b1;
      load     = 1'b0;
      value    = '0;
      mode     = 1'b0;
      dp       = '0;
      blank_lz = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_an", an, 4'hF);
      check("rst_seg", segment, 8'hFF);
      check("rst_busy", busy, 1'b0);
      clr = 1'b0;

      // reset mid-scan takes effect without a clock edge
      repeat (6) @(negedge clk);
      clr = 1'b1;
      #1;
      check("midrst_an", an, 4'hF);
      check("midrst_seg", segment, 8'hFF);
      check("midrst_busy", busy, 1'b0);
      @(negedge clk);
      clr = 1'b0;

      repeat (3) @(negedge clk);
      check("scan_pre", an, 4'hF);
      @(negedge clk);
      check("scan_0", an, 4'b1110);
      repeat (4) @(negedge clk);
      check("scan_1", an, 4'b1101);
      repeat (4) @(negedge clk);
      check("scan_2", an, 4'b1011);
      repeat (4) @(negedge clk);
      check("scan_3", an, 4'b0111);
      repeat (4) @(negedge clk);
      check("scan_wrap", an, 4'b1110);

      // hex mode
      load_val(16'h12AF, 1'b0, 4'b0100);
      check("hex_busy", busy, 1'b0);
      expect_all("hex", 8'hF9, 8'h24, 8'h88, 8'h8E);

      // decimal 1234 with an ignored hex load at busy cycle 5
      load_val(16'd1234, 1'b1, 4'b0000);
      check("dec_busy_start", busy, 1'b1);
      repeat (4) @(negedge clk);
      value = 16'hFFFF;
      mode  = 1'b0;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      wait_idle(n);
      check("dec_busy_len", n + 5, 17);
      check("dec_busy_end", busy, 1'b0);
      expect_all("dec1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

      // leading-zero blanking
      blank_lz = 1'b1;
      load_val(16'd7, 1'b1, 4'b0000);
      wait_idle(n);
      check("blank7_busy_len", n, 17);
      expect_all("blank7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
      load_val(16'd0, 1'b1, 4'b0000);
      wait_idle(n);
      expect_all("blank0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
      blank_lz = 1'b0;

      // overflow and recovery
      load_val(16'd10000, 1'b1, 4'b0000);
      wait_idle(n);
      expect_all("ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
      load_val(16'd9999, 1'b1, 4'b0000);
      wait_idle(n);
      check("d9999_busy_len", n, 17);
      expect_all("d9999", 8'h90, 8'h90, 8'h90, 8'h90);

      // reset during conversion, then a clean conversion
      load_val(16'd5678, 1'b1, 4'b0000);
      repeat (4) @(negedge clk);
      check("conv_rst_pre", busy, 1'b1);
      clr = 1'b1;
      #1;
      check("conv_rst_busy", busy, 1'b0);
      @(negedge clk);
      clr = 1'b0;
      expect_all("conv_rst_disp", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      load_val(16'd42, 1'b1, 4'b0000);
      wait_idle(n);
      check("d42_busy_len", n, 17);
      expect_all("d42", 8'hC0, 8'hC0, 8'h99, 8'hA4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
